sprite_layer_mixer: RTL and testbench

//  Parametrised N-channel sprite compositor for the VGA game renderer. Each channel computes an image-ROM address for
//  the current scan pixel, then selects the colour-keyed opaque pixel by fixed priority over the background.
//  Per-frame collision flags are raised for overlapping opaque sprites. Positions are double-buffered and take effect

---
 rtl/sprite_layer_mixer.sv | 171 +++++++++++++++++
 tb/tb_sprite_layer_mixer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer_mixer.sv
// N-channel sprite compositor: per-channel ROM addressing, colour-key transparency,
// fixed priority over background, double-buffered positions and per-frame collision flags.
module sprite_layer_mixer #(
    parameter int unsigned N_SPR   = 4,
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 9,
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned PIX_W   = 12,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [X_W-1:0]            pix_x,
    input  logic [Y_W-1:0]            pix_y,
    input  logic                      pix_valid,
    input  logic                      frame_start,
    input  logic [N_SPR*X_W-1:0]      spr_x_in,
    input  logic [N_SPR*Y_W-1:0]      spr_y_in,
    input  logic [N_SPR*X_W-1:0]      spr_w,
    input  logic [N_SPR*Y_W-1:0]      spr_h,
    input  logic [N_SPR-1:0]          spr_en_in,
    input  logic [N_SPR*PIX_W-1:0]    spr_key,
    output logic [N_SPR*ADDR_W-1:0]   spr_addr,
    input  logic [N_SPR*PIX_W-1:0]    spr_data,
    input  logic [PIX_W-1:0]          bg_data,
    output logic [PIX_W-1:0]          pix_out,
    output logic                      pix_out_valid,
    output logic [N_SPR-1:0]          hit,
    output logic [N_SPR-1:0]          collide
);

    localparam int unsigned PROD_W = X_W + Y_W + 1;
    localparam int unsigned CNT_W  = ($clog2(N_SPR + 1) < 2) ? 2 : $clog2(N_SPR + 1);

    logic [N_SPR*X_W-1:0] sh_x;
    logic [N_SPR*Y_W-1:0] sh_y;
    logic [N_SPR-1:0]     sh_en;

    // Positions latch only at frame start so objects never tear mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_x  <= '0;
            sh_y  <= '0;
            sh_en <= '0;
        end else if (frame_start) begin
            sh_x  <= spr_x_in;
            sh_y  <= spr_y_in;
            sh_en <= spr_en_in;
        end
    end

    logic [N_SPR-1:0]        box_c;
    logic [N_SPR*ADDR_W-1:0] addr_c;

    for (genvar i = 0; i < N_SPR; i++) begin : g_ch
        logic [X_W-1:0]    sx;
        logic [X_W-1:0]    w;
        logic [X_W-1:0]    dx;
        logic [Y_W-1:0]    sy;
        logic [Y_W-1:0]    h;
        logic [Y_W-1:0]    dy;
        logic [X_W:0]      x_end;
        logic [Y_W:0]      y_end;
        logic [PROD_W-1:0] lin;

        assign sx = sh_x[i*X_W +: X_W];
        assign sy = sh_y[i*Y_W +: Y_W];
        assign w  = spr_w[i*X_W +: X_W];
        assign h  = spr_h[i*Y_W +: Y_W];

        // Edge sums carry one extra bit so sprites past the screen edge clip instead of wrapping.
        assign x_end = {1'b0, sx} + {1'b0, w};
        assign y_end = {1'b0, sy} + {1'b0, h};

        assign box_c[i] = sh_en[i] & pix_valid
                        & (pix_x >= sx) & ({1'b0, pix_x} < x_end)
                        & (pix_y >= sy) & ({1'b0, pix_y} < y_end);

        assign dx  = pix_x - sx;
        assign dy  = pix_y - sy;
        assign lin = PROD_W'(dy) * PROD_W'(w) + PROD_W'(dx);

        assign addr_c[i*ADDR_W +: ADDR_W] = box_c[i] ? ADDR_W'(lin) : '0;
    end

    logic [N_SPR-1:0] box_a;
    logic             valid_a;

    // Stage A: ROM address issue plus box/valid tags for the delay line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spr_addr <= '0;
            box_a    <= '0;
            valid_a  <= 1'b0;
        end else begin
            spr_addr <= addr_c;
            box_a    <= box_c;
            valid_a  <= pix_valid;
        end
    end

    logic [N_SPR-1:0] box_dl   [ROM_LAT];
    logic             valid_dl [ROM_LAT];
    logic [N_SPR-1:0] box_d;
    logic             valid_d;

    // Tags ride alongside the ROM read so they meet spr_data/bg_data in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < ROM_LAT; k++) begin
                box_dl[k]   <= '0;
                valid_dl[k] <= 1'b0;
            end
        end else begin
            box_dl[0]   <= box_a;
            valid_dl[0] <= valid_a;
            for (int unsigned k = 1; k < ROM_LAT; k++) begin
                box_dl[k]   <= box_dl[k-1];
                valid_dl[k] <= valid_dl[k-1];
            end
        end
    end

    assign box_d   = box_dl[ROM_LAT-1];
    assign valid_d = valid_dl[ROM_LAT-1];

    logic [N_SPR-1:0] opaque_c;
    logic [PIX_W-1:0] pix_c;
    logic [CNT_W-1:0] cnt_c;
    logic             multi_c;

    // Ascending scan so the highest-index opaque channel wins over lower ones and background.
    always_comb begin
        opaque_c = '0;
        pix_c    = bg_data;
        cnt_c    = '0;
        for (int unsigned i = 0; i < N_SPR; i++) begin
            opaque_c[i] = box_d[i] & (spr_data[i*PIX_W +: PIX_W] != spr_key[i*PIX_W +: PIX_W]);
            if (opaque_c[i]) begin
                pix_c = spr_data[i*PIX_W +: PIX_W];
            end
            cnt_c = cnt_c + CNT_W'(opaque_c[i]);
        end
    end

    assign multi_c = (cnt_c >= CNT_W'(2));

    logic [N_SPR-1:0] acc;

    // Stage C output plus collision accumulation; a term landing on frame_start closes the old frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_out       <= '0;
            pix_out_valid <= 1'b0;
            hit           <= '0;
            collide       <= '0;
            acc           <= '0;
        end else begin
            pix_out       <= valid_d ? pix_c : '0;
            pix_out_valid <= valid_d;
            hit           <= opaque_c;
            if (frame_start) begin
                collide <= acc | (multi_c ? opaque_c : '0);
                acc     <= '0;
            end else if (multi_c) begin
                acc <= acc | opaque_c;
            end
        end
    end

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Bench for sprite_layer_mixer: directed vector table and corner sequences plus
// randomized scan traffic checked against a pixel-level reference model.
module tb_sprite_layer_mixer;

    localparam int N    = 4;
    localparam int XW   = 10;
    localparam int YW   = 9;
    localparam int AW   = 14;
    localparam int PW   = 12;
    localparam int LAT  = 2;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic [XW-1:0]     pix_x = '0;
    logic [YW-1:0]     pix_y = '0;
    logic              pix_valid = 1'b0;
    logic              frame_start = 1'b0;
    logic [N*XW-1:0]   spr_x_in = '0;
    logic [N*YW-1:0]   spr_y_in = '0;
    logic [N*XW-1:0]   spr_w = '0;
    logic [N*YW-1:0]   spr_h = '0;
    logic [N-1:0]      spr_en_in = '0;
    logic [N*PW-1:0]   spr_key = '0;
    logic [N*AW-1:0]   spr_addr;
    logic [N*PW-1:0]   spr_data = '0;
    logic [PW-1:0]     bg_data = '0;
    logic [PW-1:0]     pix_out;
    logic              pix_out_valid;
    logic [N-1:0]      hit;
    logic [N-1:0]      collide;

    sprite_layer_mixer #(
        .N_SPR(N), .X_W(XW), .Y_W(YW), .ADDR_W(AW), .PIX_W(PW), .ROM_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .frame_start(frame_start), .spr_x_in(spr_x_in), .spr_y_in(spr_y_in),
        .spr_w(spr_w), .spr_h(spr_h), .spr_en_in(spr_en_in), .spr_key(spr_key),
        .spr_addr(spr_addr), .spr_data(spr_data), .bg_data(bg_data),
        .pix_out(pix_out), .pix_out_valid(pix_out_valid), .hit(hit), .collide(collide)
    );

    // Sprite image ROMs and background source, two-cycle read latency.
    logic [PW-1:0]   mem [N][1<<AW];
    logic [PW-1:0]   keys [N];
    logic [N*AW-1:0] ra = '0;
    logic [XW-1:0]   qx0 = '0, qx1 = '0;
    logic [YW-1:0]   qy0 = '0, qy1 = '0;

    function automatic logic [PW-1:0] bg_fn(input int x, input int y);
        return PW'((x * 3 + y * 17) ^ 32'hA5A);
    endfunction

    always_ff @(posedge clk) begin
        ra <= spr_addr;
        for (int i = 0; i < N; i++) spr_data[i*PW +: PW] <= mem[i][ra[i*AW +: AW]];
        qx0 <= pix_x;
        qy0 <= pix_y;
        qx1 <= qx0;
        qy1 <= qy0;
        bg_data <= bg_fn(int'(qx1), int'(qy1));
    end

    int cfg_x [N], cfg_y [N], cfg_w [N], cfg_h [N];
    bit cfg_en [N];
    int sh_x [N], sh_y [N];
    bit sh_en [N];

    logic [N*AW-1:0] e_addr  [MAXC];
    logic [PW-1:0]   e_pix   [MAXC];
    logic            e_val   [MAXC];
    logic [N-1:0]    e_hit   [MAXC];
    logic [N-1:0]    op_hist [MAXC];
    logic [N-1:0]    acc_m;
    logic [N-1:0]    coll_exp;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int x;
        int y;
        int addr;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp_v);
        end
    endtask

    task automatic check_now();
        chk("spr_addr", 64'(spr_addr), 64'(e_addr[cyc]));
        chk("pix_out", 64'(pix_out), 64'(e_pix[cyc]));
        chk("pix_out_valid", 64'(pix_out_valid), 64'(e_val[cyc]));
        chk("hit", 64'(hit), 64'(e_hit[cyc]));
        chk("collide", 64'(collide), 64'(coll_exp));
    endtask

    task automatic drive_cfg();
        for (int i = 0; i < N; i++) begin
            spr_x_in[i*XW +: XW] = XW'(cfg_x[i]);
            spr_y_in[i*YW +: YW] = YW'(cfg_y[i]);
            spr_w[i*XW +: XW]    = XW'(cfg_w[i]);
            spr_h[i*YW +: YW]    = YW'(cfg_h[i]);
            spr_en_in[i]         = cfg_en[i];
            spr_key[i*PW +: PW]  = keys[i];
        end
    endtask

    // One scan cycle: check outputs, present a pixel, advance the reference model.
    task automatic step(input int x, input int y, input bit v, input bit fs);
        logic [N*AW-1:0] a;
        logic [N-1:0]    op;
        logic [N-1:0]    term;
        logic [PW-1:0]   px;
        int              j;
        int              ad;
        check_now();
        pix_x = XW'(x);
        pix_y = YW'(y);
        pix_valid = v;
        frame_start = fs;
        drive_cfg();
        a  = '0;
        op = '0;
        px = bg_fn(x, y);
        for (int i = 0; i < N; i++) begin
            if (v && sh_en[i] && x >= sh_x[i] && x < sh_x[i] + cfg_w[i]
                  && y >= sh_y[i] && y < sh_y[i] + cfg_h[i]) begin
                ad = ((y - sh_y[i]) * cfg_w[i] + (x - sh_x[i])) % (1 << AW);
                a[i*AW +: AW] = AW'(ad);
                if (mem[i][ad] != keys[i]) begin
                    op[i] = 1'b1;
                    px = mem[i][ad];
                end
            end
        end
        e_addr[cyc+1]    = a;
        e_hit[cyc+2+LAT] = op;
        e_val[cyc+2+LAT] = v;
        e_pix[cyc+2+LAT] = v ? px : '0;
        op_hist[cyc]     = op;
        j = cyc - 1 - LAT;
        term = (j >= 0) ? op_hist[j] : '0;
        if (fs) begin
            coll_exp = acc_m | (($countones(term) >= 2) ? term : '0);
            acc_m = '0;
            for (int i = 0; i < N; i++) begin
                sh_x[i]  = cfg_x[i];
                sh_y[i]  = cfg_y[i];
                sh_en[i] = cfg_en[i];
            end
        end else if ($countones(term) >= 2) begin
            acc_m = acc_m | term;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pix_valid = 1'b0;
        frame_start = 1'b0;
        #1;
        chk("rst_spr_addr", 64'(spr_addr), 64'd0);
        chk("rst_pix_out", 64'(pix_out), 64'd0);
        chk("rst_pix_out_valid", 64'(pix_out_valid), 64'd0);
        chk("rst_hit", 64'(hit), 64'd0);
        chk("rst_collide", 64'(collide), 64'd0);
        for (int i = 0; i < N; i++) begin
            sh_x[i] = 0;
            sh_y[i] = 0;
            sh_en[i] = 1'b0;
        end
        acc_m = '0;
        coll_exp = '0;
        for (int k = cyc; k <= cyc + LAT + 3; k++) begin
            e_addr[k] = '0;
            e_pix[k]  = '0;
            e_val[k]  = 1'b0;
            e_hit[k]  = '0;
        end
        for (int k = cyc - LAT - 3; k <= cyc; k++) if (k >= 0) op_hist[k] = '0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Isolated pixel: output must be absent one cycle early and present at exactly 2+LAT.
    task automatic probe(input int x, input int y, input logic [PW-1:0] ep, input logic [N-1:0] eh);
        step(0, 0, 1'b0, 1'b0);
        step(x, y, 1'b1, 1'b0);
        for (int k = 0; k < LAT; k++) step(0, 0, 1'b0, 1'b0);
        chk("probe_early_valid", 64'(pix_out_valid), 64'd0);
        step(0, 0, 1'b0, 1'b0);
        chk("probe_pix", 64'(pix_out), 64'(ep));
        chk("probe_hit", 64'(hit), 64'(eh));
        chk("probe_valid", 64'(pix_out_valid), 64'd1);
    endtask

    task automatic rand_pos(input int i);
        cfg_x[i]  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(900, 1023)) : int'($urandom_range(0, 350));
        cfg_y[i]  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(400, 511)) : int'($urandom_range(0, 220));
        cfg_en[i] = ($urandom_range(0, 4) != 0);
    endtask

    task automatic rand_geom();
        for (int i = 0; i < N; i++) begin
            cfg_w[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(500, 1023)) : int'($urandom_range(0, 120));
            cfg_h[i] = int'($urandom_range(0, 90));
            if ($urandom_range(0, 9) == 0) cfg_w[i] = 0;
        end
    endtask

    task automatic rand_run(input int cycles);
        int x;
        int y;
        for (int k = 0; k < cycles; k++) begin
            if (k % 250 == 0) rand_geom();
            if ($urandom_range(0, 9) == 0) rand_pos(int'($urandom_range(0, N - 1)));
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(850, 1023)) : int'($urandom_range(0, 399));
            y = int'($urandom_range(0, 255));
            step(x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 59) == 0);
        end
    endtask

    initial begin
        keys[0] = 12'h028;
        keys[1] = 12'h428;
        keys[2] = 12'h028;
        keys[3] = 12'h0F0;
        for (int i = 0; i < N; i++) begin
            for (int a = 0; a < (1 << AW); a++)
                mem[i][a] = ($urandom_range(0, 3) == 0) ? keys[i] : PW'($urandom);
            cfg_x[i] = 0; cfg_y[i] = 0; cfg_w[i] = 0; cfg_h[i] = 0; cfg_en[i] = 1'b0;
            sh_x[i] = 0;  sh_y[i] = 0;  sh_en[i] = 1'b0;
        end
        for (int k = 0; k < MAXC; k++) begin
            e_addr[k] = '0; e_pix[k] = '0; e_val[k] = 1'b0; e_hit[k] = '0; op_hist[k] = '0;
        end
        acc_m = '0;
        coll_exp = '0;

        tbl[0] = '{100, 50, 0};
        tbl[1] = '{146, 90, 1926};
        tbl[2] = '{147, 50, 0};
        tbl[3] = '{100, 90, 1880};
        tbl[4] = '{146, 50, 46};
        tbl[5] = '{99, 50, 0};
        tbl[6] = '{100, 91, 0};
        tbl[7] = '{120, 60, 490};

        drive_cfg();
        @(negedge clk);
        do_reset();

        // Single sprite addressing and box edges.
        cfg_x[0] = 100; cfg_y[0] = 50; cfg_w[0] = 47; cfg_h[0] = 41; cfg_en[0] = 1'b1;
        step(0, 0, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(tbl[k].x, tbl[k].y, 1'b1, 1'b0);
            chk("tbl_addr0", 64'(spr_addr[AW-1:0]), 64'(tbl[k].addr));
        end
        mem[0][1926] = 12'h777;
        probe(146, 90, 12'h777, 4'b0001);
        probe(147, 50, bg_fn(147, 50), 4'b0000);

        // Overlapping opaque sprites: priority and collision flag on next frame start.
        cfg_x[1] = 110; cfg_y[1] = 60; cfg_w[1] = 20; cfg_h[1] = 20; cfg_en[1] = 1'b1;
        step(0, 0, 1'b0, 1'b1);
        mem[0][720] = 12'h111;
        mem[1][105] = 12'h222;
        probe(115, 65, 12'h222, 4'b0011);
        step(0, 0, 1'b0, 1'b1);
        chk("collide_overlap", 64'(collide), 64'h3);

        // Colour-keyed pixels are transparent and never collide.
        mem[0][768] = 12'h028;
        mem[1][126] = 12'h333;
        probe(116, 66, 12'h333, 4'b0010);
        mem[0][48] = 12'h028;
        probe(101, 51, bg_fn(101, 51), 4'b0000);
        step(0, 0, 1'b0, 1'b1);
        chk("collide_keyed", 64'(collide), 64'h0);

        // Mid-frame position change takes effect only at the next frame start.
        mem[0][1] = 12'h444;
        cfg_x[0] = 300;
        probe(101, 50, 12'h444, 4'b0001);
        step(0, 0, 1'b0, 1'b1);
        probe(301, 50, 12'h444, 4'b0001);
        probe(101, 50, bg_fn(101, 50), 4'b0000);

        // Right-edge clipping with no wrap to column 0.
        cfg_x[2] = 620; cfg_y[2] = 0; cfg_w[2] = 62; cfg_h[2] = 10; cfg_en[2] = 1'b1;
        step(0, 0, 1'b0, 1'b1);
        mem[2][19] = 12'h555;
        step(639, 0, 1'b1, 1'b0);
        chk("clip_addr2", 64'(spr_addr[2*AW +: AW]), 64'd19);
        probe(639, 0, 12'h555, 4'b0100);
        probe(0, 0, bg_fn(0, 0), 4'b0000);
        probe(41, 0, bg_fn(41, 0), 4'b0000);

        // Random traffic, a mid-stream reset, then more traffic.
        rand_run(3000);
        do_reset();
        rand_run(1500);
        for (int k = 0; k < LAT + 4; k++) step(0, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
